// File: rtl/alu_pkg.sv
// Shared definitions for the execution-side ALU: operation codes,
// the FSM state type and a shift-code helper.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_code(input logic [2:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: working register, counter, done pulse.
// Ports: clk/reset, start (latch operands), run (shift this cycle), op,
// shamt, data_in; done is high in the cycle whose shift yields the final
// value, data_out is the working register shifted by one more bit.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     run,
    input  logic [2:0]               op,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     done,
    output logic [WIDTH-1:0]         data_out
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] work;
    logic [SW-1:0]    count;
    logic [2:0]       code;

    always_comb begin
        data_out = work;
        case (code)
            ALU_SLL: data_out = work << 1;
            ALU_SRL: data_out = work >> 1;
            ALU_SRA: data_out = {work[WIDTH-1], work[WIDTH-1:1]};
            default: data_out = work;
        endcase
    end

    // The shift performed while count==1 is the last one.
    assign done = run && (count == SW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            work  <= '0;
            count <= '0;
            code  <= ALU_ADD;
        end else if (start) begin
            work  <= data_in;
            count <= shamt;
            code  <= op;
        end else if (run) begin
            work  <= data_out;
            count <= count - SW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execution ALU: add/sub/and/or/slt in one registered cycle behind a
// valid/ready handshake, result held in a one-deep output register.
// Ports: clk, reset (sync, active high), in_valid/in_ready, alu_control,
// src_a, src_b, out_valid/out_ready, result, zero, illegal.
// Define ALU_EXEC_SHIFT_EN to add the iterative sll/srl/sra shifter;
// without it shift codes complete in one cycle flagged illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t           state;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [WIDTH-1:0] ld_res;
    logic             ld_ill;

    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_control)
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                $signed(src_a) < $signed(src_b)};
            default: begin
`ifdef ALU_EXEC_SHIFT_EN
                // Only a zero-amount shift completes here: identity.
                alu_res = src_a;
`else
                alu_ill = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    localparam int SW = $clog2(WIDTH);

    state_t           state_nx;
    logic [SW-1:0]    shamt;
    logic             start;
    logic             done;
    logic [WIDTH-1:0] sh_res;

    assign shamt = src_b[SW-1:0];
    assign start = accept && is_shift_code(alu_control) && (shamt != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: if (done)  state_nx = IDLE;
        endcase
    end

    alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .run      (state == SHIFT),
        .op       (alu_control),
        .shamt    (shamt),
        .data_in  (src_a),
        .done     (done),
        .data_out (sh_res)
    );

    // No accept can coincide with done: in_ready is low during SHIFT.
    assign load   = (accept && !start) || done;
    assign ld_res = done ? sh_res : alu_res;
    assign ld_ill = done ? 1'b0 : alu_ill;
`else
    assign state  = IDLE;
    assign load   = accept;
    assign ld_res = alu_res;
    assign ld_ill = alu_ill;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= ld_res;
            zero      <= (ld_res == '0);
            illegal   <= ld_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_EXEC_SHIFT_EN
    localparam bit SHIFT_BUILD = 1'b1;
`else
    localparam bit SHIFT_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_control;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference function: returns {illegal, result}.
    function automatic logic [W:0] ref_alu(input logic [2:0] c,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sh;
        logic [W-1:0] r;
        sh = int'(b[4:0]);
        case (c)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin
                if (!SHIFT_BUILD) return {1'b1, {W{1'b0}}};
                if (c == 3'd4)      r = a << sh;
                else if (c == 3'd6) r = a >> sh;
                else                r = W'($signed(a) >>> sh);
            end
        endcase
        return {1'b0, r};
    endfunction

    // Model state: expected output register plus cycles left in a shift.
    logic         m_ov   = 1'b0;
    logic         m_zero = 1'b0;
    logic         m_ill  = 1'b0;
    logic [W-1:0] m_res  = '0;
    logic [W-1:0] m_sval = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        bit         rdy;
        bit         ld;
        logic [W:0] v;
        rdy = !reset && m_left == 0 && (!m_ov || out_ready);
        ld  = 1'b0;
        v   = '0;
        if (reset) begin
            m_ov   = 1'b0;
            m_res  = '0;
            m_zero = 1'b0;
            m_ill  = 1'b0;
            m_left = 0;
        end else begin
            if (m_left == 1) begin
                ld     = 1'b1;
                v      = {1'b0, m_sval};
                m_left = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else if (in_valid && rdy) begin
                v = ref_alu(alu_control, src_a, src_b);
                if (SHIFT_BUILD && alu_control inside {3'd4, 3'd6, 3'd7}
                    && src_b[4:0] != 5'd0) begin
                    m_left = int'(src_b[4:0]);
                    m_sval = v[W-1:0];
                end else begin
                    ld = 1'b1;
                end
            end
            if (ld) begin
                m_ov   = 1'b1;
                m_res  = v[W-1:0];
                m_ill  = v[W];
                m_zero = (v[W-1:0] == '0);
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready,
                !reset && m_left == 0 && (!m_ov || out_ready));
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("result", result, m_res);
                chk("zero", zero, m_zero);
                chk("illegal", illegal, m_ill);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid    = v;
        alu_control = c;
        src_a       = a;
        src_b       = b;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, ALU_ADD, '0, '0);
        step;
        step;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 0);

        reset = 1'b0;
        drive(1'b1, ALU_ADD, 32'h5, 32'h7);
        step;
        chk("add_valid", out_valid, 1);
        chk("add_res", result, 32'hC);
        chk("add_zero", zero, 0);
        chk("add_illegal", illegal, 0);
        drive(1'b1, ALU_SUB, 32'h5, 32'h5);
        step;
        chk("sub_res", result, 32'h0);
        chk("sub_zero", zero, 1);
        drive(1'b1, ALU_AND, 32'hF0F0, 32'hFF00);
        step;
        chk("and_valid", out_valid, 1);
        chk("and_res", result, 32'hF000);
        drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        step;
        chk("slt_res", result, 32'h1);
        drive(1'b1, ALU_OR, 32'h0, 32'h0);
        step;
        chk("or_res", result, 32'h0);
        chk("or_zero", zero, 1);

        drive(1'b1, ALU_ADD, 32'h1, 32'h2);
        step;
        chk("bp_first", result, 32'h3);
        drive(1'b1, ALU_SUB, 32'h9, 32'h4);
        out_ready = 1'b0;
        #1;
        chk("bp_ready_lo", in_ready, 0);
        step;
        chk("bp_hold1", result, 32'h3);
        chk("bp_ready_lo2", in_ready, 0);
        step;
        chk("bp_hold2", result, 32'h3);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_hi", in_ready, 1);
        step;
        chk("bp_second", result, 32'h5);
        in_valid = 1'b0;
        step;
        chk("bp_drain", out_valid, 0);

`ifdef ALU_EXEC_SHIFT_EN
        drive(1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
        step;
        in_valid = 1'b0;
        chk("sra_busy0", in_ready, 0);
        for (int i = 1; i < 4; i++) begin
            step;
            chk("sra_busy", in_ready, 0);
            chk("sra_novalid", out_valid, 0);
        end
        step;
        chk("sra_valid", out_valid, 1);
        chk("sra_res", result, 32'hF800_0000);

        drive(1'b1, ALU_SLL, 32'h1, 32'd10);
        step;
        in_valid = 1'b0;
        step;
        reset = 1'b1;
        step;
        chk("abort_valid", out_valid, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            step;
            chk("abort_quiet", out_valid, 0);
        end
`else
        drive(1'b1, 3'b111, 32'h8000_0000, 32'd4);
        step;
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_res", result, 0);
        chk("ill_zero", zero, 1);
        step;
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = '0;
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b);
            step;
        end

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) step;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
